rocc_cmd_buffer: RTL and testbench

//  Decoupling stage between the core's RoCC command port and a RoCC accelerator.

---
 rtl/rocc_cmd_buffer.sv | 118 +++++++++++
 tb/tb_rocc_cmd_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rocc_cmd_buffer.sv
// Command FIFO with outstanding-response credits between a core's RoCC port and an accelerator.
// Define ROCC_CMD_BUF_BYPASS_EN for a zero-latency path from in_cmd to out_cmd when the FIFO is empty.
module rocc_cmd_buffer #(
  parameter int XLEN            = 64,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     in_cmd_ready,
  input  logic                     in_cmd_valid,
  input  logic [6:0]               in_cmd_funct,
  input  logic [4:0]               in_cmd_rd,
  input  logic                     in_cmd_xd,
  input  logic [6:0]               in_cmd_opcode,
  input  logic [XLEN-1:0]          in_cmd_rs1,
  input  logic [XLEN-1:0]          in_cmd_rs2,
  input  logic                     out_cmd_ready,
  output logic                     out_cmd_valid,
  output logic [6:0]               out_cmd_funct,
  output logic [4:0]               out_cmd_rd,
  output logic                     out_cmd_xd,
  output logic [6:0]               out_cmd_opcode,
  output logic [XLEN-1:0]          out_cmd_rs1,
  output logic [XLEN-1:0]          out_cmd_rs2,
  output logic                     acc_resp_ready,
  input  logic                     acc_resp_valid,
  input  logic [4:0]               acc_resp_rd,
  input  logic [XLEN-1:0]          acc_resp_data,
  input  logic                     core_resp_ready,
  output logic                     core_resp_valid,
  output logic [4:0]               core_resp_rd,
  output logic [XLEN-1:0]          core_resp_data,
  output logic                     rocc_busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_unexpected_resp
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int EW = 2 * XLEN + 20;

  logic [EW-1:0]  mem [DEPTH];
  logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [OW-1:0]  outstanding_reg;
  logic           err_reg;
  logic           full, empty, credit_full, head_xd;
  logic           push, pop_fifo, issue, resp_fire, inc;
  logic [EW-1:0]  in_entry, head_entry, sel_entry;

  // Entry layout: {funct, rd, xd, opcode, rs1, rs2}
  assign in_entry    = {in_cmd_funct, in_cmd_rd, in_cmd_xd, in_cmd_opcode, in_cmd_rs1, in_cmd_rs2};
  assign head_entry  = mem[rd_ptr_reg[AW-1:0]];
  assign head_xd     = head_entry[2*XLEN+7];

  assign empty       = (wr_ptr_reg == rd_ptr_reg);
  assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                       (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign credit_full = (outstanding_reg == OW'(MAX_OUTSTANDING));
  assign in_cmd_ready = !full;

`ifdef ROCC_CMD_BUF_BYPASS_EN
  logic bypass_take;
  // An incoming command goes straight out only when nothing is queued ahead of it.
  assign bypass_take   = empty && in_cmd_valid && !(in_cmd_xd && credit_full);
  assign sel_entry     = bypass_take ? in_entry : head_entry;
  assign out_cmd_valid = bypass_take || (!empty && !(head_xd && credit_full));
  assign push          = in_cmd_valid && !full && !(bypass_take && out_cmd_ready);
  assign rocc_busy     = !empty || (outstanding_reg != '0) || in_cmd_valid;
`else
  assign sel_entry     = head_entry;
  assign out_cmd_valid = !empty && !(head_xd && credit_full);
  assign push          = in_cmd_valid && !full;
  assign rocc_busy     = !empty || (outstanding_reg != '0);
`endif

  assign {out_cmd_funct, out_cmd_rd, out_cmd_xd, out_cmd_opcode, out_cmd_rs1, out_cmd_rs2} = sel_entry;

  assign issue     = out_cmd_valid && out_cmd_ready;
  assign pop_fifo  = issue && !empty;
  assign inc       = issue && out_cmd_xd;
  assign resp_fire = acc_resp_valid && core_resp_ready;

  assign acc_resp_ready      = core_resp_ready;
  assign core_resp_valid     = acc_resp_valid;
  assign core_resp_rd        = acc_resp_rd;
  assign core_resp_data      = acc_resp_data;
  assign count               = wr_ptr_reg - rd_ptr_reg;
  assign err_unexpected_resp = err_reg;

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= in_entry;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      outstanding_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      if (push)     wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_fifo) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({inc, resp_fire})
        2'b10:   outstanding_reg <= outstanding_reg + OW'(1);
        2'b01:   if (outstanding_reg != '0) outstanding_reg <= outstanding_reg - OW'(1);
        default: outstanding_reg <= outstanding_reg;
      endcase
      // A response with no credit outstanding is a protocol error; it latches until reset.
      if (resp_fire && (outstanding_reg == '0)) err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rocc_cmd_buffer.sv
// Randomized and directed bench for rocc_cmd_buffer against a queue-based reference model.
module tb_rocc_cmd_buffer;
  localparam int XLEN  = 64;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  typedef struct packed {
    logic [6:0]      funct;
    logic [4:0]      rd;
    logic            xd;
    logic [6:0]      opcode;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } cmd_t;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_cmd_ready, in_cmd_valid, in_cmd_xd;
  logic [6:0]      in_cmd_funct, in_cmd_opcode;
  logic [4:0]      in_cmd_rd;
  logic [XLEN-1:0] in_cmd_rs1, in_cmd_rs2;
  logic            out_cmd_ready, out_cmd_valid, out_cmd_xd;
  logic [6:0]      out_cmd_funct, out_cmd_opcode;
  logic [4:0]      out_cmd_rd;
  logic [XLEN-1:0] out_cmd_rs1, out_cmd_rs2;
  logic            acc_resp_ready, acc_resp_valid;
  logic [4:0]      acc_resp_rd;
  logic [XLEN-1:0] acc_resp_data;
  logic            core_resp_ready, core_resp_valid;
  logic [4:0]      core_resp_rd;
  logic [XLEN-1:0] core_resp_data;
  logic            rocc_busy;
  logic [2:0]      count;
  logic            err_unexpected_resp;

  always #5 clock = ~clock;

  rocc_cmd_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .in_cmd_ready(in_cmd_ready), .in_cmd_valid(in_cmd_valid), .in_cmd_funct(in_cmd_funct),
    .in_cmd_rd(in_cmd_rd), .in_cmd_xd(in_cmd_xd), .in_cmd_opcode(in_cmd_opcode),
    .in_cmd_rs1(in_cmd_rs1), .in_cmd_rs2(in_cmd_rs2),
    .out_cmd_ready(out_cmd_ready), .out_cmd_valid(out_cmd_valid), .out_cmd_funct(out_cmd_funct),
    .out_cmd_rd(out_cmd_rd), .out_cmd_xd(out_cmd_xd), .out_cmd_opcode(out_cmd_opcode),
    .out_cmd_rs1(out_cmd_rs1), .out_cmd_rs2(out_cmd_rs2),
    .acc_resp_ready(acc_resp_ready), .acc_resp_valid(acc_resp_valid), .acc_resp_rd(acc_resp_rd),
    .acc_resp_data(acc_resp_data), .core_resp_ready(core_resp_ready),
    .core_resp_valid(core_resp_valid), .core_resp_rd(core_resp_rd), .core_resp_data(core_resp_data),
    .rocc_busy(rocc_busy), .count(count), .err_unexpected_resp(err_unexpected_resp)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  cmd_t q[$];
  int   outs   = 0;
  bit   err_m  = 0;
  longint seq  = 1;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic cmd_t mk_cmd(input bit xd, input longint rs1);
    cmd_t c;
    c.funct  = 7'($urandom);
    c.rd     = 5'($urandom);
    c.xd     = xd;
    c.opcode = 7'($urandom);
    c.rs1    = rs1;
    c.rs2    = {$urandom, $urandom};
    return c;
  endfunction

  // One clock: drive inputs, compare against the model, then advance the model by the observed handshakes.
  task automatic step(input bit rst_n, input bit iv, input cmd_t c, input bit ordy,
                      input bit rv, input logic [4:0] rrd, input logic [XLEN-1:0] rdat,
                      input bit crdy, input bit chk);
    cmd_t head;
    bit   exp_v, exp_rdy, exp_busy, byp, pop, push, inc, rfire;
    reset = rst_n;
    in_cmd_valid = iv;
    {in_cmd_funct, in_cmd_rd, in_cmd_xd, in_cmd_opcode, in_cmd_rs1, in_cmd_rs2} = c;
    out_cmd_ready = ordy;
    acc_resp_valid = rv;
    acc_resp_rd = rrd;
    acc_resp_data = rdat;
    core_resp_ready = crdy;
    #1;
    exp_rdy = (q.size() < DEPTH);
    exp_v = 0;
    byp = 0;
    head = '0;
    exp_busy = (q.size() > 0) || (outs > 0);
    if (q.size() > 0) begin
      head = q[0];
      exp_v = !(head.xd && outs == MAXO);
    end
`ifdef ROCC_CMD_BUF_BYPASS_EN
    else if (iv && !(c.xd && outs == MAXO)) begin
      head = c;
      exp_v = 1;
      byp = 1;
    end
    exp_busy = exp_busy || iv;
`endif
    if (chk) begin
      check_eq("in_ready", in_cmd_ready, exp_rdy);
      check_eq("out_valid", out_cmd_valid, exp_v);
      if (exp_v)
        check_eq("out_fields", {out_cmd_funct, out_cmd_rd, out_cmd_xd, out_cmd_opcode,
                                out_cmd_rs1, out_cmd_rs2}, head);
      check_eq("busy", rocc_busy, exp_busy);
      check_eq("count", count, q.size());
      check_eq("err", err_unexpected_resp, err_m);
      check_eq("resp_pass", {core_resp_valid, core_resp_rd, core_resp_data, acc_resp_ready},
               {rv, rrd, rdat, crdy});
    end
    @(posedge clock);
    if (!rst_n) begin
      q.delete();
      outs = 0;
      err_m = 0;
    end else begin
      pop   = exp_v && ordy;
      push  = iv && exp_rdy && !(byp && ordy);
      inc   = pop && head.xd;
      rfire = rv && crdy;
      if (pop && !byp) void'(q.pop_front());
      if (push) q.push_back(c);
      if (rfire && outs == 0) err_m = 1;
      if (inc && !rfire) outs++;
      else if (rfire && !inc && outs > 0) outs--;
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, 1, 0, 0, 0, 1, 1);
  endtask

  task automatic do_reset();
    step(0, 0, '0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic settle_idle();
    reset = 1; in_cmd_valid = 0; out_cmd_ready = 0; acc_resp_valid = 0; core_resp_ready = 0;
    #1;
  endtask

  initial begin
    cmd_t c;
    int   k;
    bit   acc;

    // Reset held with a command presented: nothing may be queued.
    c = mk_cmd(0, 64'h77);
    step(0, 1, c, 0, 0, 0, 0, 0, 0);
    step(0, 1, c, 0, 0, 0, 0, 0, 1);
    step(0, 1, c, 0, 0, 0, 0, 0, 1);
    reset = 0; #1;
    check_eq("rst_count", count, 0);
    check_eq("rst_in_ready", in_cmd_ready, 1);
    check_eq("rst_out_valid", out_cmd_valid, 0);

    // Fill to DEPTH with the accelerator stalled, then drain in order.
    k = 1;
    for (int cyc = 0; cyc < 20 && k <= 5; cyc++) begin
      acc = (q.size() < DEPTH);
      step(1, 1, mk_cmd(0, k), cyc >= 6, 0, 0, 0, 1, 1);
      if (acc) k++;
      if (cyc == 3) begin
        check_eq("full_count", count, 4);
        check_eq("full_in_ready", in_cmd_ready, 0);
      end
    end
    check_eq("all5_accepted", k, 6);
    idle(6);
    settle_idle();
    check_eq("drained_count", count, 0);

    // Credit limit: third xd command waits for a response.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, mk_cmd(1, 100 + i), 1, 0, 0, 0, 1, 1);
    idle(3);
    settle_idle();
    check_eq("credit_hold_valid", out_cmd_valid, 0);
    check_eq("credit_hold_count", count, 1);
    step(1, 0, '0, 1, 1, 5'd5, 64'hAB, 1, 1);
    settle_idle();
    check_eq("credit_release_valid", out_cmd_valid, 1);
    idle(1);

    // Issue and response in the same cycle at one credit outstanding.
    step(1, 0, '0, 1, 1, 5'd1, 64'h1, 1, 1);
    step(1, 1, mk_cmd(1, 200), 0, 0, 0, 0, 1, 1);
    step(1, 0, '0, 1, 1, 5'd2, 64'h2, 1, 1);
    settle_idle();
    check_eq("same_cycle_busy", rocc_busy, 1);
    check_eq("same_cycle_count", count, 0);
    step(1, 0, '0, 1, 1, 5'd3, 64'h3, 1, 1);
    settle_idle();
    check_eq("idle_busy", rocc_busy, 0);

    // Unexpected response latches the error until reset.
    step(1, 0, '0, 1, 1, 5'd4, 64'h4, 1, 1);
    idle(3);
    settle_idle();
    check_eq("err_sticky", err_unexpected_resp, 1);
    check_eq("err_busy", rocc_busy, 0);
    do_reset();
    settle_idle();
    check_eq("err_cleared", err_unexpected_resp, 0);

    // Random traffic across many pointer wraps.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit iv, rv;
      iv = ($urandom_range(0, 9) < 6);
      rv = (outs > 0) && ($urandom_range(0, 2) == 0);
      c  = mk_cmd(1'($urandom), seq);
      if (iv && q.size() < DEPTH) seq++;
      step(1, iv, c, 1'($urandom), rv, 5'($urandom), {$urandom, $urandom},
           ($urandom_range(0, 9) < 7), 1);
    end
    for (int i = 0; i < 20; i++) step(1, 0, '0, 1, (outs > 0), 5'd0, 64'h0, 1, 1);
    settle_idle();
    check_eq("final_busy", rocc_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
